// File: rtl/ps2_scan_decoder.sv
// ----------------------------------------------------------------------------
// ps2_scan_decoder
//   Receives PS/2 keyboard frames and turns the scan-code stream into
//   key events. The raw PS/2 lines are synchronized and the clock is
//   deglitched before use. Each byte is framed as start / 8 data bits
//   (LSB first) / odd parity / stop. A small FSM folds the 0xE0
//   (extended) and 0xF0 (break) prefixes into the event that follows.
//
//   Optional feature macro: PS2_PARITY_CHECK_EN
//     defined   : frames with bad (even) parity are discarded with frame_err
//     undefined : the parity bit is shifted in and ignored
//
// Parameters
//   FILTER_LEN     consecutive equal samples needed to move the filtered clock
//   TIMEOUT_CYCLES clk cycles without a falling edge that abort a partial frame
//
// Ports
//   clk           system clock (single domain)
//   reset         asynchronous, active-high reset
//   ps2_clk       raw PS/2 clock line (asynchronous)
//   ps2_data      raw PS/2 data line (asynchronous)
//   key_code      last decoded scan code, held between events
//   key_pressed   1 = make, 0 = break, held between events
//   key_extended  1 = code was preceded by 0xE0, held between events
//   key_valid     one-cycle pulse when the three key outputs update
//   frame_err     one-cycle pulse when a frame is discarded
// ----------------------------------------------------------------------------
module ps2_scan_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 65000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_code,
    output logic       key_pressed,
    output logic       key_extended,
    output logic       key_valid,
    output logic       frame_err
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, BREAK, EXT, EXT_BREAK} state_t;

    // ------------------------------------------------------------------
    // Input synchronizers; idle PS/2 lines are high.
    // ------------------------------------------------------------------
    logic [1:0] r_clk_sync;
    logic [1:0] r_data_sync;
    logic       w_clk_s;
    logic       w_data_s;

    // NOTE: every clocked register is written with non-blocking assignments so
    // all flops update together from the values present before the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], ps2_clk};
            r_data_sync <= {r_data_sync[0], ps2_data};
        end
    end

    assign w_clk_s  = r_clk_sync[1];
    assign w_data_s = r_data_sync[1];

    // ------------------------------------------------------------------
    // Clock deglitch: the filtered clock follows the synchronized clock only
    // after FILTER_LEN consecutive samples disagree with it.
    // ------------------------------------------------------------------
    logic          r_filt_clk;
    logic [FW-1:0] r_filt_cnt;
    logic          w_filt_commit;
    logic          w_fall;

    assign w_filt_commit = (w_clk_s != r_filt_clk) && (r_filt_cnt == FW'(FILTER_LEN - 1));
    assign w_fall        = w_filt_commit && !w_clk_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_filt_clk <= 1'b1;
            r_filt_cnt <= '0;
        end else if (w_clk_s == r_filt_clk) begin
            r_filt_cnt <= '0;
        end else if (w_filt_commit) begin
            r_filt_clk <= w_clk_s;
            r_filt_cnt <= '0;
        end else begin
            r_filt_cnt <= r_filt_cnt + FW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Frame receiver. r_bit_cnt: 0 = waiting for start, 1..9 = data+parity,
    // 10 = stop. Data and parity shift in from the top, so after nine shifts
    // r_shift[7:0] is the byte and r_shift[8] the parity bit.
    // ------------------------------------------------------------------
    logic [3:0]    r_bit_cnt;
    logic [8:0]    r_shift;
    logic [TW-1:0] r_tmo_cnt;
    logic          r_byte_done;
    logic          r_rx_err;
    logic          w_frame_ok;

`ifdef PS2_PARITY_CHECK_EN
    assign w_frame_ok = w_data_s && (^r_shift);
`else
    assign w_frame_ok = w_data_s;
`endif

    // NOTE: the shift register is reset along with the control state; it is
    // only nine flops and a defined value keeps the decoder input clean.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_tmo_cnt   <= '0;
            r_byte_done <= 1'b0;
            r_rx_err    <= 1'b0;
        end else begin
            r_byte_done <= 1'b0;
            r_rx_err    <= 1'b0;
            if (r_bit_cnt == 4'd0) begin
                // Idle: timeout disabled; a start bit sampled as 1 is ignored.
                r_tmo_cnt <= '0;
                if (w_fall && !w_data_s) begin
                    r_bit_cnt <= 4'd1;
                end
            end else if (w_fall) begin
                r_tmo_cnt <= '0;
                if (r_bit_cnt == 4'd10) begin
                    r_bit_cnt <= 4'd0;
                    if (w_frame_ok) begin
                        r_byte_done <= 1'b1;
                    end else begin
                        r_rx_err <= 1'b1;
                    end
                end else begin
                    r_shift   <= {w_data_s, r_shift[8:1]};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
            end else if (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                r_tmo_cnt <= '0;
                r_bit_cnt <= 4'd0;
                r_rx_err  <= 1'b1;
            end else begin
                r_tmo_cnt <= r_tmo_cnt + TW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Prefix decoder FSM. r_shift[7:0] is stable during the byte_done cycle
    // because the next falling edge is at least FILTER_LEN cycles away.
    // ------------------------------------------------------------------
    state_t r_state;
    state_t w_next;
    logic   w_emit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: defaults are assigned first so every path drives every output and
    // no latch is inferred.
    always_comb begin
        w_next = r_state;
        w_emit = 1'b0;
        if (r_rx_err) begin
            w_next = IDLE;
        end else if (r_byte_done) begin
            if (r_shift[7:0] == 8'hE0) begin
                w_next = EXT;
            end else if (r_shift[7:0] == 8'hF0) begin
                w_next = (r_state == EXT || r_state == EXT_BREAK) ? EXT_BREAK : BREAK;
            end else begin
                w_emit = 1'b1;
                w_next = IDLE;
            end
        end
    end

    logic [7:0] r_key_code;
    logic       r_key_pressed;
    logic       r_key_extended;
    logic       r_key_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_key_code     <= 8'h00;
            r_key_pressed  <= 1'b0;
            r_key_extended <= 1'b0;
            r_key_valid    <= 1'b0;
        end else begin
            r_key_valid <= w_emit;
            if (w_emit) begin
                r_key_code     <= r_shift[7:0];
                r_key_pressed  <= (r_state == IDLE) || (r_state == EXT);
                r_key_extended <= (r_state == EXT) || (r_state == EXT_BREAK);
            end
        end
    end

    assign key_code     = r_key_code;
    assign key_pressed  = r_key_pressed;
    assign key_extended = r_key_extended;
    assign key_valid    = r_key_valid;
    assign frame_err    = r_rx_err;

endmodule

// File: doc/ps2_scan_decoder.md
PS2_SCAN_DECODER -- requirements
Module: ps2_scan_decoder

Interface
REQ-001 Parameter FILTER_LEN, default 8, SHALL be the number of consecutive equal synchronized ps2_clk samples required before the filtered PS/2 clock changes.
REQ-002 Parameter TIMEOUT_CYCLES, default 65000, SHALL be the number of clk cycles without a filtered falling edge, mid-frame, that aborts the frame.
REQ-003 clk  input  1  system clock; all logic SHALL be in this single domain.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 ps2_clk  input  1  raw PS/2 clock line, asynchronous to clk.
REQ-006 ps2_data  input  1  raw PS/2 data line, asynchronous to clk.
REQ-007 key_code  output  8  last decoded key scan code, held between events.
REQ-008 key_pressed  output  1  1 = make, 0 = break for key_code, held between events.
REQ-009 key_extended  output  1  1 = key_code was preceded by the 0xE0 prefix, held between events.
REQ-010 key_valid  output  1  one-cycle pulse when key_code/key_pressed/key_extended update.
REQ-011 frame_err  output  1  one-cycle pulse on a discarded frame.

Function
REQ-012 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer before use.
REQ-013 The filtered clock SHALL change only after FILTER_LEN consecutive identical synchronized samples; shorter glitches SHALL have no effect.
REQ-014 A 1->0 transition of the filtered clock SHALL sample synchronized ps2_data once.
REQ-015 Frame = 11 bits: start(0), 8 data LSB first, odd parity, stop(1); a 0..10 bit counter SHALL track position.
REQ-016 Start bit sampled as 1: the bit SHALL be ignored, receiver stays idle, no frame_err.
REQ-017 Stop bit sampled as 0: frame SHALL be discarded, frame_err pulses.
REQ-018 Mid-frame (counter 1..10), TIMEOUT_CYCLES clk cycles without a falling edge: counter SHALL return to 0, frame_err pulses; timeout counter is inactive when idle.
REQ-019 Accepted byte SHALL raise an internal byte_done strobe in the cycle after the stop-bit edge; decoder outputs update and key_valid pulses in the cycle after byte_done (latency 2 clk from stop-bit edge detect).
REQ-020 Decoder FSM states: IDLE, BREAK, EXT, EXT_BREAK; reset state IDLE.
REQ-021 0xE0 from any state -> EXT; 0xF0 from IDLE or BREAK -> BREAK; 0xF0 from EXT or EXT_BREAK -> EXT_BREAK; prefix bytes SHALL NOT pulse key_valid or change outputs.
REQ-022 Any other byte: key_code <= byte; key_pressed <= 1 in IDLE/EXT, 0 in BREAK/EXT_BREAK; key_extended <= 1 in EXT/EXT_BREAK, else 0; key_valid pulses; FSM -> IDLE.
REQ-023 Repeated make bytes (typematic) SHALL each pulse key_valid with identical outputs.
REQ-024 Any frame_err SHALL also force the decoder FSM to IDLE (pending prefix dropped); outputs unchanged.
REQ-025 key_code/key_pressed/key_extended SHALL stay stable between key_valid pulses so a downstream per-key tracker sampling every cycle sees a constant code.

Reset
REQ-026 On reset: key_code = 0x00, key_pressed = 0, key_extended = 0, key_valid = 0, frame_err = 0, bit counter = 0, timeout counter = 0, filtered clock = 1, FSM = IDLE.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame; the first complete frame after release SHALL decode normally.

Configuration
REQ-028 Macro PS2_PARITY_CHECK_EN defined: a frame whose data+parity bits have even count of ones SHALL be discarded with a frame_err pulse and no decoder update.
REQ-029 PS2_PARITY_CHECK_EN undefined: the parity bit SHALL be sampled and ignored; no parity check logic.

Verification
REQ-030 Frame 0x1D -> key_valid one pulse, key_code 0x1D, key_pressed 1, key_extended 0, 2 clk after stop edge.
REQ-031 Frames 0xF0, 0x1D -> no key_valid after 0xF0; after 0x1D: key_code 0x1D, key_pressed 0, key_extended 0.
REQ-032 Frames 0xE0,0x75 then 0xE0,0xF0,0x75 -> first: 0x75/pressed 1/extended 1; second: 0x75/pressed 0/extended 1; exactly two key_valid pulses.
REQ-033 Frame 0x1C with wrong parity -> with PS2_PARITY_CHECK_EN: frame_err pulse, no key_valid, outputs unchanged; without: key_code 0x1C, pressed 1.
REQ-034 Frame stopped after 5 bits, idle TIMEOUT_CYCLES -> frame_err pulse; next frame 0x23 decodes to key_code 0x23, pressed 1.
REQ-035 ps2_clk glitch of FILTER_LEN-1 cycles mid-frame, then reset at bit 4 -> no extra bit captured; reset gives all outputs 0; next frame 0x1B decodes correctly.
